// File: rtl/uart_dbus_master_pkg.sv
// ============================================================================
// Module : uart_dbus_master_pkg
// Brief  : Shared state encodings, dbus widths and default command bytes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_dbus_master_pkg;

    localparam int c_DBUS_AW = 8;
    localparam int c_DBUS_DW = 8;

    localparam logic [7:0] c_DEF_CMD_WR   = 8'h57;
    localparam logic [7:0] c_DEF_CMD_RD   = 8'h52;
    localparam logic [7:0] c_DEF_RESP_ERR = 8'h3F;
    localparam logic [7:0] c_DEF_RESP_ACK = 8'h4B;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        BUS_WR   = 3'd3,
        BUS_RD   = 3'd4,
        TX_WAIT  = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_dbus_timer.sv
// ============================================================================
// Module : uart_dbus_timer
// Brief  : Inter-byte timeout counter; done flags the last idle cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_dbus_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            logic w_unused_tmr;
            assign w_unused_tmr = sysclk ^ reset ^ clear ^ enable;
            assign done         = 1'b0;
        end else begin : g_counter
            localparam int             c_W    = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [c_W-1:0] c_TERM = c_W'(TIMEOUT_CYCLES - 1);

            logic [c_W-1:0] r_count;

            always_ff @(posedge sysclk or posedge reset) begin
                if (reset) begin
                    r_count <= '0;
                end else if (clear) begin
                    r_count <= '0;
                end else if (enable && !done) begin
                    r_count <= r_count + c_W'(1);
                end
            end

            // Terminal count: the FSM leaves on the edge that completes the window.
            assign done = enable && (r_count == c_TERM);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/uart_dbus_master.sv
// ============================================================================
// Module : uart_dbus_master
// Brief  : UART byte stream to register-bus initiator (W addr data / R addr).
//          `UART_DBUS_WRACK_EN: send RESP_ACK after every completed write.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_dbus_master
    import uart_dbus_master_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] CMD_WR         = c_DEF_CMD_WR,
    parameter logic [7:0] CMD_RD         = c_DEF_CMD_RD,
    parameter logic [7:0] RESP_ERR       = c_DEF_RESP_ERR,
    parameter logic [7:0] RESP_ACK       = c_DEF_RESP_ACK
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [c_DBUS_AW-1:0] uart_reg,
    output logic [c_DBUS_DW-1:0] uart_dbus_in,
    output logic                 uart_dbus_w,
    output logic                 uart_dbus_r,
    input  logic [c_DBUS_DW-1:0] uart_dbus_out,
    output logic                 busy,
    output logic                 rx_drop
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_is_wr;
    logic [7:0]           r_tx_data;
    logic [c_DBUS_AW-1:0] r_reg;
    logic [c_DBUS_DW-1:0] r_din;
    logic                 r_rx_drop;
    logic                 w_in_get;
    logic                 w_timeout;
    logic                 w_is_cmd;

    assign w_in_get = (r_state == GET_ADDR) || (r_state == GET_DATA);
    assign w_is_cmd = (rx_data == CMD_WR) || (rx_data == CMD_RD);

    uart_dbus_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .sysclk (sysclk),
        .reset  (reset),
        .clear  (rx_valid || !w_in_get),
        .enable (w_in_get),
        .done   (w_timeout)
    );

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        uart_dbus_w = 1'b0;
        uart_dbus_r = 1'b0;
        tx_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_valid) begin
                    w_state_nxt = w_is_cmd ? GET_ADDR : TX_WAIT;
                end
            end
            // A byte arriving on the timeout cycle still counts.
            GET_ADDR: begin
                if (rx_valid) begin
                    w_state_nxt = r_is_wr ? GET_DATA : BUS_RD;
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
                    w_state_nxt = BUS_WR;
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            BUS_WR: begin
                uart_dbus_w = 1'b1;
`ifdef UART_DBUS_WRACK_EN
                w_state_nxt = TX_WAIT;
`else
                w_state_nxt = IDLE;
`endif
            end
            BUS_RD: begin
                uart_dbus_r = 1'b1;
                w_state_nxt = TX_WAIT;
            end
            TX_WAIT: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_is_wr   <= 1'b0;
            r_tx_data <= '0;
            r_reg     <= '0;
            r_din     <= '0;
            r_rx_drop <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rx_valid) begin
                        if (w_is_cmd) begin
                            r_is_wr <= (rx_data == CMD_WR);
                        end else begin
                            r_tx_data <= RESP_ERR;
                        end
                    end
                end
                GET_ADDR: begin
                    if (rx_valid) begin
                        r_reg <= rx_data;
                    end
                end
                GET_DATA: begin
                    if (rx_valid) begin
                        r_din <= rx_data;
                    end
                end
                BUS_RD: begin
                    r_tx_data <= uart_dbus_out;
                end
`ifdef UART_DBUS_WRACK_EN
                BUS_WR: begin
                    r_tx_data <= RESP_ACK;
                end
`endif
                default: begin
                end
            endcase
            if (rx_valid && (r_state == BUS_WR || r_state == BUS_RD || r_state == TX_WAIT)) begin
                r_rx_drop <= 1'b1;
            end
        end
    end

`ifndef UART_DBUS_WRACK_EN
    logic w_unused_ack;
    assign w_unused_ack = ^RESP_ACK;
`endif

    assign tx_data      = r_tx_data;
    assign uart_reg     = r_reg;
    assign uart_dbus_in = r_din;
    assign busy         = (r_state != IDLE);
    assign rx_drop      = r_rx_drop;

endmodule

`default_nettype wire
